brick_fall_sequencer: RTL and testbench
=======================================

# brick_fall_sequencer

Game-flow controller for the three-column falling-brick game. It spawns each brick, advances its row on a gravity timer, detects landing on the stack under the current column, updates the three stack heights, clears a full bottom line and flags game over. Its `row` and `hauteur*` outputs feed the column controller and the display. It samples the column controller's `Col` output once per gravity tick.

## Interface
Parameters:
- `ROW_COUNT`, 6: rows per column. Row 0 is the top; a stack of height h occupies rows ROW_COUNT-h .. ROW_COUNT-1.
- `GRAVITY_PERIOD`, 50_000_000: clk cycles per row step at normal speed (≥2).
- `FAST_PERIOD`, 5_000_000: clk cycles per row step while `drop` is high (≥1, ≤ GRAVITY_PERIOD).

Ports:
- `clk`  in  1  system clock; all state on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle pulse that starts or restarts a game.
- `drop`  in  1  level; selects FAST_PERIOD.
- `col`  in  2  current brick column (0 left, 1 centre, 2 right). The value 3 is treated as 1.
- `row`  out  3  current brick row.
- `hauteurGauche` / `hauteurCentre` / `hauteurDroite`  out  3 each  stack heights.
- `new_brick`  out  1  one-cycle pulse when a brick spawns; the column controller uses it to recentre.
- `landed`  out  1  one-cycle pulse when a brick is absorbed into a stack.
- `score`  out  8  cleared lines, saturating at 255.
- `game_over`  out  1  level, high in OVER.
- `busy`  out  1  high in SPAWN, FALL, LAND and CLEAR.

## Operation
- States: IDLE, SPAWN, FALL, LAND, CLEAR, OVER.
- Reset (asynchronous, any state):
  - State goes to IDLE.
  - row=0, all heights=0, score=0.
  - new_brick=0, landed=0, game_over=0, busy=0.
  - Tick counter=0.
- IDLE: hold outputs; on `start` go to SPAWN.
- SPAWN (1 cycle):
  - If hauteurCentre == ROW_COUNT, go to OVER.
  - Otherwise: row←0, tick counter←0, new_brick=1 for this cycle, go to FALL.
- FALL:
  - Tick counter increments each cycle.
  - A tick fires when counter ≥ (drop ? FAST_PERIOD : GRAVITY_PERIOD) - 1. On a tick the counter resets to 0.
  - On a tick, take h = height of the column `col` selects in that cycle.
    - If row == ROW_COUNT-1-h, go to LAND.
    - Otherwise row←row+1.
- LAND (1 cycle):
  - h[col latched at tick] ← h+1, saturating at ROW_COUNT. landed=1.
  - If all three heights are ≥1 after the update, go to CLEAR; otherwise go to SPAWN.
- CLEAR (1 cycle):
  - Every height ←height-1.
  - score←score+1, saturating at 255.
  - Go to SPAWN.
- OVER: game_over=1, row is held. On `start`: heights←0, score←0, game_over←0, go to SPAWN.
- `start` is ignored in SPAWN, FALL, LAND and CLEAR.
- Column legality is the column controller's job. This block trusts `col` and uses it only at ticks.
- Arithmetic:
  - ROW_COUNT-1-h is computed at 4-bit signed width.
  - A column with h == ROW_COUNT cannot be selected by a legal `col`. If it is, landing triggers immediately at the next tick with no height change beyond saturation.

## Timing
- start at cycle n: SPAWN at n+1, new_brick high during n+1, FALL from n+2.
- Row k→k+1 updates on the tick cycle. Ticks occur every P cycles (P = active period), with the first tick P cycles after FALL entry.
- Landing tick → LAND next cycle (landed high). Height update is visible the cycle after LAND.
- Without a clear: LAND → SPAWN (+1) → FALL (+2).
- With a clear: LAND → CLEAR → SPAWN adds one cycle.
- `drop` changes take effect on the next compare. Raising `drop` when counter ≥ FAST_PERIOD-1 fires a tick on that cycle.
- Reset asserted mid-FALL forces IDLE values immediately. Leaving reset resumes in IDLE.

## Test plan
All scenarios use ROW_COUNT=6, GRAVITY_PERIOD=4, FAST_PERIOD=2.
- Reset then start, col=1, empty board:
  - new_brick pulses once; row steps 0→5 every 4 cycles.
  - Landing tick at row 5 → landed pulse; hauteurCentre=1, others 0; new_brick again, row=0.
- Drop held from spawn onto left stack (hauteurGauche=2, col=0): row steps every 2 cycles and lands at row 3 → hauteurGauche=3.
- Heights G=1, C=0, D=1, brick lands in the centre:
  - Sequence LAND→CLEAR → heights 0,0,0, score=1.
  - Next new_brick one cycle later than in the no-clear case.
- hauteurCentre=6 at SPAWN:
  - game_over=1, busy=0, no new_brick.
  - start → heights and score 0, new_brick pulses, game_over=0.
- Reset pulled low mid-FALL at row 3: row=0, heights=0, score=0 immediately, state IDLE. start ignored while reset is low.
- col switches 1→2 between ticks with hauteurDroite=4: landing occurs at row 1 of column 2, and only hauteurDroite increments.

Source files
------------

// File: rtl/brick_fall_sequencer.sv
// Game-flow controller for the three-column falling-brick game: spawns bricks,
// applies gravity, lands them on the column stacks, clears full bottom lines.
module brick_fall_sequencer #(
  parameter int ROW_COUNT      = 6,
  parameter int GRAVITY_PERIOD = 50_000_000,
  parameter int FAST_PERIOD    = 5_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       drop,
  input  logic [1:0] col,
  output logic [2:0] row,
  output logic [2:0] hauteurGauche,
  output logic [2:0] hauteurCentre,
  output logic [2:0] hauteurDroite,
  output logic       new_brick,
  output logic       landed,
  output logic [7:0] score,
  output logic       game_over,
  output logic       busy
);

  localparam int                CNT_W    = $clog2(GRAVITY_PERIOD + 1);
  localparam logic [CNT_W-1:0]  GRAV_LIM = CNT_W'(GRAVITY_PERIOD - 1);
  localparam logic [CNT_W-1:0]  FAST_LIM = CNT_W'(FAST_PERIOD - 1);
  localparam logic [2:0]        H_MAX    = 3'(ROW_COUNT);
  localparam logic signed [3:0] LAST_ROW = 4'(ROW_COUNT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SPAWN, S_FALL, S_LAND, S_CLEAR, S_OVER
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] tick_cnt_q;
  logic [2:0]       row_q;
  logic [2:0]       hg_q, hc_q, hd_q;
  logic [7:0]       score_q;
  logic [1:0]       land_col_q;

  function automatic logic [2:0] sat_inc_height(input logic [2:0] h);
    return (h >= H_MAX) ? H_MAX : h + 3'd1;
  endfunction

  function automatic logic [7:0] sat_inc_score(input logic [7:0] s);
    return (s == 8'hFF) ? s : s + 8'd1;
  endfunction

  function automatic logic [1:0] norm_col(input logic [1:0] c);
    return (c == 2'd3) ? 2'd1 : c;
  endfunction

  logic [1:0]        col_n;
  logic [2:0]        sel_h;
  logic signed [3:0] land_target;
  logic              tick;
  logic              land_hit;
  logic [2:0]        hg_upd, hc_upd, hd_upd;
  logic              all_filled;

  assign col_n = norm_col(col);

  always_comb begin
    sel_h = hc_q;
    case (col_n)
      2'd0:    sel_h = hg_q;
      2'd2:    sel_h = hd_q;
      default: sel_h = hc_q;
    endcase
  end

  // A full column gives a negative target, so the >= compare lands at once.
  assign land_target = LAST_ROW - $signed({1'b0, sel_h});
  assign land_hit    = $signed({1'b0, row_q}) >= land_target;
  assign tick        = tick_cnt_q >= (drop ? FAST_LIM : GRAV_LIM);

  assign hg_upd     = (land_col_q == 2'd0) ? sat_inc_height(hg_q) : hg_q;
  assign hc_upd     = (land_col_q == 2'd1) ? sat_inc_height(hc_q) : hc_q;
  assign hd_upd     = (land_col_q == 2'd2) ? sat_inc_height(hd_q) : hd_q;
  assign all_filled = (hg_upd != 3'd0) && (hc_upd != 3'd0) && (hd_upd != 3'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    new_brick = 1'b0;
    landed    = 1'b0;
    game_over = 1'b0;
    busy      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_SPAWN;
      end
      S_SPAWN: begin
        busy = 1'b1;
        if (hc_q == H_MAX) begin
          state_d = S_OVER;
        end else begin
          new_brick = 1'b1;
          state_d   = S_FALL;
        end
      end
      S_FALL: begin
        busy = 1'b1;
        if (tick && land_hit) state_d = S_LAND;
      end
      S_LAND: begin
        busy    = 1'b1;
        landed  = 1'b1;
        state_d = all_filled ? S_CLEAR : S_SPAWN;
      end
      S_CLEAR: begin
        busy    = 1'b1;
        state_d = S_SPAWN;
      end
      S_OVER: begin
        game_over = 1'b1;
        if (start) state_d = S_SPAWN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Gravity counter, brick row and the column captured at the landing tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_cnt_q <= '0;
      row_q      <= 3'd0;
      land_col_q <= 2'd1;
    end else begin
      case (state_q)
        S_SPAWN: begin
          if (hc_q != H_MAX) begin
            row_q      <= 3'd0;
            tick_cnt_q <= '0;
          end
        end
        S_FALL: begin
          if (tick) begin
            tick_cnt_q <= '0;
            land_col_q <= col_n;
            if (!land_hit) row_q <= row_q + 3'd1;
          end else begin
            tick_cnt_q <= tick_cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Stack heights and score.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hg_q    <= 3'd0;
      hc_q    <= 3'd0;
      hd_q    <= 3'd0;
      score_q <= 8'd0;
    end else begin
      case (state_q)
        S_LAND: begin
          hg_q <= hg_upd;
          hc_q <= hc_upd;
          hd_q <= hd_upd;
        end
        S_CLEAR: begin
          hg_q    <= hg_q - 3'd1;
          hc_q    <= hc_q - 3'd1;
          hd_q    <= hd_q - 3'd1;
          score_q <= sat_inc_score(score_q);
        end
        S_OVER: begin
          if (start) begin
            hg_q    <= 3'd0;
            hc_q    <= 3'd0;
            hd_q    <= 3'd0;
            score_q <= 8'd0;
          end
        end
        default: ;
      endcase
    end
  end

  assign row           = row_q;
  assign hauteurGauche = hg_q;
  assign hauteurCentre = hc_q;
  assign hauteurDroite = hd_q;
  assign score         = score_q;

endmodule

// File: tb/tb_brick_fall_sequencer.sv
// Directed bench for brick_fall_sequencer with ROW_COUNT=6, GRAVITY_PERIOD=4, FAST_PERIOD=2.
module tb_brick_fall_sequencer;

  localparam int ROWS = 6;
  localparam int GP   = 4;
  localparam int FP   = 2;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       drop  = 1'b0;
  logic [1:0] col   = 2'd1;
  logic [2:0] row;
  logic [2:0] hauteurGauche, hauteurCentre, hauteurDroite;
  logic       new_brick, landed, game_over, busy;
  logic [7:0] score;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  brick_fall_sequencer #(
    .ROW_COUNT     (ROWS),
    .GRAVITY_PERIOD(GP),
    .FAST_PERIOD   (FP)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .drop         (drop),
    .col          (col),
    .row          (row),
    .hauteurGauche(hauteurGauche),
    .hauteurCentre(hauteurCentre),
    .hauteurDroite(hauteurDroite),
    .new_brick    (new_brick),
    .landed       (landed),
    .score        (score),
    .game_over    (game_over),
    .busy         (busy)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check_heights(input string tag, input int g, input int c, input int d);
    check_val({tag, "_hg"}, hauteurGauche, g);
    check_val({tag, "_hc"}, hauteurCentre, c);
    check_val({tag, "_hd"}, hauteurDroite, d);
  endtask

  task automatic start_game();
    start = 1'b1;
    step();
    start = 1'b0;
    check_val("start_new_brick", new_brick, 1);
    check_val("start_busy", busy, 1);
  endtask

  // Called at the SPAWN cycle; returns at the LAND cycle.
  task automatic drop_brick(input logic [1:0] c, input logic d, input int land_row);
    int p;
    p    = d ? FP : GP;
    col  = c;
    drop = d;
    step();
    check_val("fall_entry_row", row, 0);
    check_val("fall_entry_nb", new_brick, 0);
    for (int r = 1; r <= land_row; r++) begin
      repeat (p - 1) step();
      check_val("row_hold", row, r - 1);
      step();
      check_val("row_step", row, r);
    end
    repeat (p - 1) step();
    check_val("no_early_land", landed, 0);
    step();
    check_val("landed", landed, 1);
    check_val("land_row", row, land_row);
  endtask

  initial begin
    // Reset state
    #12;
    step();
    check_val("rst_row", row, 0);
    check_heights("rst", 0, 0, 0);
    check_val("rst_score", score, 0);
    check_val("rst_nb", new_brick, 0);
    check_val("rst_landed", landed, 0);
    check_val("rst_go", game_over, 0);
    check_val("rst_busy", busy, 0);
    reset = 1'b1;
    step();
    step();
    check_val("idle_busy", busy, 0);

    // Centre brick on an empty board, normal speed
    start_game();
    drop_brick(2'd1, 1'b0, 5);
    check_heights("s1_at_land", 0, 0, 0);
    step();
    check_val("s1_respawn_nb", new_brick, 1);
    check_heights("s1", 0, 1, 0);
    check_val("s1_score", score, 0);

    // Build a left stack with drop held, third brick lands at row 3
    drop_brick(2'd0, 1'b1, 5);
    step();
    drop_brick(2'd0, 1'b1, 4);
    step();
    drop_brick(2'd0, 1'b1, 3);
    step();
    check_val("s2_nb", new_brick, 1);
    check_heights("s2", 3, 1, 0);

    // start ignored in FALL, then reset pulled mid-fall at row 3
    col  = 2'd1;
    drop = 1'b0;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    check_val("start_ign_busy", busy, 1);
    check_val("start_ign_nb", new_brick, 0);
    repeat (3 * GP - 1) step();
    check_val("s5_row_before", row, 3);
    #2;
    reset = 1'b0;
    #1;
    check_val("s5_row", row, 0);
    check_heights("s5", 0, 0, 0);
    check_val("s5_score", score, 0);
    check_val("s5_busy", busy, 0);
    check_val("s5_nb", new_brick, 0);
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    check_val("s5_start_ign_busy", busy, 0);
    check_val("s5_start_ign_nb", new_brick, 0);
    reset = 1'b1;
    step();
    step();
    check_val("s5_idle_busy", busy, 0);

    // Line clear: G=1, D=1, brick lands in centre
    start_game();
    drop_brick(2'd0, 1'b1, 5);
    step();
    drop_brick(2'd2, 1'b1, 5);
    step();
    check_heights("s3_pre", 1, 0, 1);
    drop_brick(2'd1, 1'b1, 5);
    step();
    check_val("s3_clear_nb", new_brick, 0);
    check_val("s3_clear_busy", busy, 1);
    check_heights("s3_clear", 1, 1, 1);
    step();
    check_val("s3_spawn_nb", new_brick, 1);
    check_heights("s3", 0, 0, 0);
    check_val("s3_score", score, 1);

    // Fill the centre column to ROW_COUNT and hit game over
    for (int k = 0; k < ROWS; k++) begin
      drop_brick(2'd1, 1'b1, ROWS - 1 - k);
      step();
      if (k < ROWS - 1) check_val("s4_fill_nb", new_brick, 1);
    end
    check_val("s4_spawn_nb", new_brick, 0);
    check_val("s4_hc", hauteurCentre, 6);
    step();
    check_val("s4_go", game_over, 1);
    check_val("s4_busy", busy, 0);
    check_val("s4_nb", new_brick, 0);
    check_val("s4_row", row, 0);
    check_val("s4_score", score, 1);
    step();
    check_val("s4_go_hold", game_over, 1);
    start_game();
    check_val("s4_restart_go", game_over, 0);
    check_heights("s4_restart", 0, 0, 0);
    check_val("s4_restart_score", score, 0);

    // Right stack of 4, then switch column mid-fall
    drop_brick(2'd2, 1'b1, 5);
    step();
    drop_brick(2'd2, 1'b1, 4);
    step();
    drop_brick(2'd2, 1'b1, 3);
    step();
    drop_brick(2'd2, 1'b1, 2);
    step();
    check_heights("s6_pre", 0, 0, 4);
    col  = 2'd1;
    drop = 1'b0;
    step();
    check_val("s6_entry_row", row, 0);
    repeat (GP) step();
    check_val("s6_row1", row, 1);
    col = 2'd2;
    repeat (GP) step();
    check_val("s6_landed", landed, 1);
    check_val("s6_land_row", row, 1);
    step();
    check_val("s6_nb", new_brick, 1);
    check_heights("s6", 0, 0, 5);

    // col=3 behaves as centre
    drop_brick(2'd3, 1'b1, 5);
    step();
    check_heights("col3", 0, 1, 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
